// File: rtl/sdram_port_arbiter.sv
// Round-robin owner of the SDRAM command interface for the four FIFO ports.
// One command is in flight at a time; it is held until acked or timed out, then released.
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int ASIZE       = 23,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               INIT_REQ,
  input  logic [3:0]         REQ,
  input  logic [3:0]         REQ_WR,
  input  logic [4*ASIZE-1:0] REQ_ADDR,
  input  logic               CMD_ACK,
  output logic [2:0]         CMD,
  output logic [ASIZE-1:0]   ADDR,
  output logic [3:0]         GRANT,
  output logic [3:0]         DONE,
  output logic [3:0]         ERR,
  output logic               BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_RELEASE} state_e;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;
  localparam logic [9:0] TIMEOUT_C  = 10'(ACK_TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [9:0]       timer_q, timer_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;
  logic [3:0]       err_q, err_d;
  logic             busy_q, busy_d;

  logic [ASIZE-1:0] port_addr [4];
  logic [1:0]       winner;

  // Priority rotates so the port after the previous owner is looked at first.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    for (int p = 0; p < 4; p++) port_addr[p] = REQ_ADDR[p*ASIZE +: ASIZE];
    winner = rr_pick(REQ, last_q);
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first, so no
    // path through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (!INIT_REQ && (REQ != 4'b0000)) begin
          grant_d = 4'b0001 << winner;
          cmd_d   = REQ_WR[winner] ? CMD_WRITEA : CMD_READA;
          addr_d  = port_addr[winner];
          last_d  = winner;
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        timer_d = timer_q + 10'd1;
        if (CMD_ACK) begin
          cmd_d   = CMD_NOP;
          done_d  = grant_q;
          state_d = S_RELEASE;
        end else if (timer_q == TIMEOUT_C) begin
          cmd_d   = CMD_NOP;
          err_d   = grant_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // GRANT stays up for this one NOP cycle so the decoder sees CMD drop.
        grant_d = '0;
        done_d  = '0;
        err_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements appear in.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      timer_q <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign CMD   = cmd_q;
  assign ADDR  = addr_q;
  assign GRANT = grant_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: random transactions checked against a queue-based
// round-robin model that predicts owner, command, address and handshake timing.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ASIZE       = 23;
  localparam int ACK_TIMEOUT = 1023;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               INIT_REQ;
  logic [3:0]         REQ;
  logic [3:0]         REQ_WR;
  logic [4*ASIZE-1:0] REQ_ADDR;
  logic               CMD_ACK;
  logic [2:0]         CMD;
  logic [ASIZE-1:0]   ADDR;
  logic [3:0]         GRANT;
  logic [3:0]         DONE;
  logic [3:0]         ERR;
  logic               BUSY;

  int checks = 0;
  int errors = 0;
  int rr_q[$];

  sdram_port_arbiter #(.ASIZE(ASIZE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INIT_REQ(INIT_REQ), .REQ(REQ), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .CMD_ACK(CMD_ACK), .CMD(CMD), .ADDR(ADDR), .GRANT(GRANT),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Model: ports queued in service order; the winner is the first requesting
  // port in the queue, and the queue is rotated so the winner goes last.
  task automatic model_reset();
    rr_q = '{0, 1, 2, 3};
  endtask

  function automatic int model_pick(input logic [3:0] req);
    int w;
    w = -1;
    for (int i = 0; i < rr_q.size(); i++)
      if (w < 0 && req[rr_q[i]]) w = rr_q[i];
    return w;
  endfunction

  task automatic model_commit(input int p);
    int x;
    do begin
      x = rr_q.pop_front();
      rr_q.push_back(x);
    end while (x != p);
  endtask

  function automatic logic [4*ASIZE-1:0] rand_addr();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[4*ASIZE-1:0];
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RESET_N  = 1'b0;
    INIT_REQ = 1'b0;
    REQ      = '0;
    REQ_WR   = '0;
    REQ_ADDR = '0;
    CMD_ACK  = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    model_reset();
  endtask

  // Called at a negedge with the DUT idle and REQ set up. The command must
  // appear one edge later, stay for d cycles, then NOP+DONE/ERR, then idle.
  task automatic serve(input int d, input bit ack, input bit drop, input bit scramble,
                       input bit init_mid, output logic [3:0] got);
    int               w;
    logic [2:0]       ecmd;
    logic [ASIZE-1:0] eaddr;
    logic [3:0]       eg;
    got = 'x;
    w = model_pick(REQ);
    if (w < 0 || INIT_REQ) begin
      checks++;
      errors++;
      $display("FAIL serve_setup req=%b init=%b", REQ, INIT_REQ);
      return;
    end
    eg    = 4'b0001 << w;
    ecmd  = REQ_WR[w] ? 3'b010 : 3'b001;
    eaddr = REQ_ADDR[w*ASIZE +: ASIZE];
    model_commit(w);
    tick();
    got = GRANT;
    for (int k = 0; k < d; k++) begin
      checks++;
      if ({CMD, ADDR, GRANT, DONE, ERR, BUSY} !== {ecmd, eaddr, eg, 4'b0, 4'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold k=%0d got cmd=%b addr=%h grant=%b done=%b err=%b busy=%b exp cmd=%b addr=%h grant=%b",
                 k, CMD, ADDR, GRANT, DONE, ERR, BUSY, ecmd, eaddr, eg);
      end
      if (scramble) begin
        REQ      = 4'($urandom);
        REQ_WR   = 4'($urandom);
        REQ_ADDR = rand_addr();
      end
      if (init_mid && k == 0) INIT_REQ = 1'b1;
      CMD_ACK = ack && (k == d - 1);
      tick();
    end
    CMD_ACK = 1'b0;
    checks++;
    if ({CMD, GRANT, DONE, ERR, BUSY} !== {3'b000, eg, (ack ? eg : 4'b0), (ack ? 4'b0 : eg), 1'b1}) begin
      errors++;
      $display("FAIL finish got cmd=%b grant=%b done=%b err=%b busy=%b exp grant=%b %s",
               CMD, GRANT, DONE, ERR, BUSY, eg, ack ? "done" : "err");
    end
    if (drop) REQ[w] = 1'b0;
    tick();
    checks++;
    if ({CMD, GRANT, DONE, ERR, BUSY} !== 15'b0) begin
      errors++;
      $display("FAIL release got cmd=%b grant=%b done=%b err=%b busy=%b exp all zero",
               CMD, GRANT, DONE, ERR, BUSY);
    end
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    INIT_REQ = 1'b0;
    REQ      = 4'b1111;
    REQ_WR   = 4'b1111;
    REQ_ADDR = rand_addr();
    CMD_ACK  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({CMD, ADDR, GRANT, DONE, ERR, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_values got cmd=%b addr=%h grant=%b done=%b err=%b busy=%b exp all zero",
               CMD, ADDR, GRANT, DONE, ERR, BUSY);
    end
    REQ = '0;
    RESET_N = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_init_block();
    logic [3:0] got;
    apply_reset();
    INIT_REQ = 1'b1;
    REQ      = 4'b0001;
    REQ_WR   = 4'b0000;
    REQ_ADDR = rand_addr();
    repeat (50) begin
      tick();
      checks++;
      if (GRANT !== 4'b0 || CMD !== 3'b000 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL init_block got grant=%b cmd=%b busy=%b exp 0000 000 0", GRANT, CMD, BUSY);
      end
    end
    INIT_REQ = 1'b0;
    serve(3, 1'b1, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL init_release_grant got %b exp 0001", got);
    end
  endtask

  task automatic test_port2_write();
    logic [3:0] got;
    REQ      = 4'b0100;
    REQ_WR   = 4'b0100;
    REQ_ADDR = rand_addr();
    REQ_ADDR[2*ASIZE +: ASIZE] = 23'h12345;
    serve(4, 1'b1, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (got !== 4'b0100) begin
      errors++;
      $display("FAIL port2_grant got %b exp 0100", got);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] got;
    apply_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      REQ_WR   = 4'($urandom);
      REQ_ADDR = rand_addr();
      serve(2, 1'b1, 1'b0, 1'b0, 1'b0, got);
      checks++;
      if (got !== (4'b0001 << (i % 4))) begin
        errors++;
        $display("FAIL fairness i=%0d got %b exp %b", i, got, 4'b0001 << (i % 4));
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] got;
    REQ      = 4'b1010;
    REQ_WR   = 4'($urandom);
    REQ_ADDR = rand_addr();
    serve(ACK_TIMEOUT + 1, 1'b0, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (got !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_grant got %b exp 0010", got);
    end
    serve(3, 1'b1, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (got !== 4'b1000) begin
      errors++;
      $display("FAIL after_timeout_grant got %b exp 1000", got);
    end
  endtask

  task automatic test_ack_on_timeout();
    logic [3:0] got;
    REQ      = 4'b0001 << $urandom_range(0, 3);
    REQ_WR   = 4'($urandom);
    REQ_ADDR = rand_addr();
    serve(ACK_TIMEOUT + 1, 1'b1, 1'b1, 1'b0, 1'b0, got);
  endtask

  task automatic test_idle_ack();
    REQ = '0;
    for (int i = 0; i < 4; i++) begin
      CMD_ACK = i[0];
      tick();
      checks++;
      if ({CMD, GRANT, DONE, ERR, BUSY} !== 15'b0) begin
        errors++;
        $display("FAIL idle_ack got cmd=%b grant=%b done=%b err=%b busy=%b exp all zero",
                 CMD, GRANT, DONE, ERR, BUSY);
      end
    end
    CMD_ACK = 1'b0;
  endtask

  task automatic test_init_mid();
    logic [3:0] got;
    REQ      = 4'b0001 << $urandom_range(0, 3);
    REQ_WR   = 4'($urandom);
    REQ_ADDR = rand_addr();
    serve(5, 1'b1, 1'b0, 1'b0, 1'b1, got);
    REQ = 4'b1111;
    repeat (5) begin
      tick();
      checks++;
      if (GRANT !== 4'b0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL init_mid_block got grant=%b busy=%b exp 0000 0", GRANT, BUSY);
      end
    end
    INIT_REQ = 1'b0;
    serve(2, 1'b1, 1'b0, 1'b0, 1'b0, got);
  endtask

  task automatic test_random();
    logic [3:0] got;
    for (int n = 0; n < 40; n++) begin
      do REQ = 4'($urandom); while (REQ == 4'b0);
      REQ_WR   = 4'($urandom);
      REQ_ADDR = rand_addr();
      serve($urandom_range(1, 8), 1'b1, 1'b0, 1'($urandom), 1'b0, got);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    REQ      = 4'b1111;
    REQ_WR   = 4'($urandom);
    REQ_ADDR = rand_addr();
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b1 || GRANT === 4'b0) begin
      errors++;
      $display("FAIL reset_mid_setup got busy=%b grant=%b exp busy 1 with a grant", BUSY, GRANT);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({CMD, GRANT, DONE, ERR, BUSY} !== 15'b0) begin
      errors++;
      $display("FAIL reset_mid got cmd=%b grant=%b done=%b err=%b busy=%b exp all zero",
               CMD, GRANT, DONE, ERR, BUSY);
    end
    tick();
    tick();
    checks++;
    if ({CMD, GRANT, DONE, ERR, BUSY} !== 15'b0) begin
      errors++;
      $display("FAIL reset_hold got cmd=%b grant=%b done=%b err=%b busy=%b exp all zero",
               CMD, GRANT, DONE, ERR, BUSY);
    end
    RESET_N = 1'b1;
    model_reset();
    serve(2, 1'b1, 1'b0, 1'b0, 1'b0, got);
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b exp 0001", got);
    end
  endtask

  initial begin
    test_reset();
    test_init_block();
    test_port2_write();
    test_fairness();
    test_timeout();
    test_ack_on_timeout();
    test_idle_ack();
    test_init_mid();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Round-robin arbiter that shares the SDRAM command interface (CMD/ADDR in, CMD_ACK out of the SDRAM command decoder) between four requesters: two write FIFOs and two read FIFOs in the 4-port SDRAM controller.
- Grants one requester at a time and drives its READA/WRITEA command and address.
- Holds the command until acknowledged, then releases the bus.
- Blocks all grants while the SDRAM init sequence runs (INIT_REQ high).
- Flags a port whose command is never acknowledged within a timeout.

Parameters:
ASIZE, 23, SDRAM address width; matches the controller's `ASIZE`.
ACK_TIMEOUT, 1023, max cycles in WAIT_ACK before abort; counter is 10 bits wide.

Ports:
CLK  input  1  system clock
RESET_N  input  1  asynchronous active-low reset
INIT_REQ  input  1  SDRAM init in progress; no grant while 1
REQ  input  4  per-port request, bit p = port p; held until DONE[p] or ERR[p]
REQ_WR  input  4  per-port direction, 1 = WRITEA, 0 = READA; valid while REQ[p]
REQ_ADDR  input  4*ASIZE  port p address at bits [p*ASIZE +: ASIZE]
CMD_ACK  input  1  single-cycle command acknowledge from the command decoder
CMD  output  3  000 NOP, 001 READA, 010 WRITEA
ADDR  output  ASIZE  address of the granted port
GRANT  output  4  one-hot current owner, 0 when idle
DONE  output  4  one-cycle pulse on the granted port's bit when its command is acked
ERR  output  4  one-cycle pulse on the granted port's bit on timeout
BUSY  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: CMD=000, ADDR=0, GRANT=0, DONE=0, ERR=0, BUSY=0, state=IDLE, last=3, timer=0.
- All outputs are registered.
- States: IDLE, WAIT_ACK, RELEASE.
- IDLE:
  - Sample REQ when INIT_REQ==0 and REQ!=0.
  - Winner = first set bit scanning last+1, last+2, last+3, last (mod 4).
  - Next edge: GRANT=onehot(winner), CMD=(REQ_WR[winner] ? 010 : 001), ADDR=REQ_ADDR slice, last=winner, timer=0, state=WAIT_ACK.
  - Latency from REQ sampled high (idle, no init) to CMD valid: 1 cycle.
- WAIT_ACK:
  - CMD, ADDR and GRANT are held constant; REQ/REQ_WR/REQ_ADDR changes are ignored.
  - timer increments every cycle.
  - CMD_ACK==1: next edge CMD=000, DONE[winner]=1, state=RELEASE.
  - CMD_ACK==0 and timer==ACK_TIMEOUT: next edge CMD=000, ERR[winner]=1, state=RELEASE.
  - CMD_ACK and timeout in the same cycle: ack wins; DONE pulses, ERR does not.
- RELEASE:
  - Exactly one cycle with CMD=000 and GRANT still set, so the decoder's CMD_ACK toggle-detect sees the drop.
  - Next edge: GRANT=0, DONE=0, ERR=0, state=IDLE.
  - REQ is not sampled in this state; a requester drops REQ on seeing DONE.
  - Minimum spacing between successive commands: 3 cycles after ack.
- INIT_REQ rising while in WAIT_ACK or RELEASE: the current transaction completes normally; no new grant until INIT_REQ==0.
- CMD_ACK in IDLE or RELEASE: ignored; no DONE.
- Fairness: with all 4 ports requesting continuously, grant order is 0,1,2,3,0,...
- RESET_N low at any time: asynchronous return to reset values; any in-flight command is dropped with no DONE or ERR.

Test Plan:
- Reset, INIT_REQ=1, REQ=4'b0001 for 50 cycles -> CMD=000, GRANT=0 throughout. Drop INIT_REQ -> 1 cycle later GRANT=0001, CMD=001 (REQ_WR=0), ADDR=REQ_ADDR[22:0].
- Port 2 write, REQ_WR[2]=1, addr 23'h12345; CMD_ACK pulsed 4 cycles after grant -> CMD=010/ADDR=23'h12345 held 4 cycles, then CMD=000 with DONE=0100 for 1 cycle, GRANT=0 one cycle later.
- REQ=1111 held, ack 2 cycles after each grant -> grants 0001,0010,0100,1000,0001 in order, each with exactly one DONE pulse.
- Port 1 granted, CMD_ACK never asserted -> ERR=0010 pulses at timer==1023 (1024 cycles after CMD valid), CMD returns to 000, next requester is then served.
- CMD_ACK in the same cycle as timer==1023 -> DONE pulses, no ERR. CMD_ACK pulsed while idle -> no DONE.
- RESET_N low mid-WAIT_ACK -> same cycle CMD=000, GRANT=0, BUSY=0. After release, REQ=1111 -> port 0 granted first.
